sram_arbiter: RTL
=================

// Module: sram_arbiter
//
// PURPOSE
// Round-robin arbiter sharing the single 16-bit SRAM controller between N_PORTS requesters.
// Sits between client blocks and the SRAM controller's command interface.
// Grants one requester, issues one read or write strobe, and waits for the controller's ready pulse.
// Returns read data plus a one-cycle ack to the winner; a watchdog aborts hung transactions.
//
// PARAMETERS
// N_PORTS   4    number of requesters (2..8)
// ADDR_W    21   SRAM byte address width
// DATA_W    16   word width
// TIMEOUT   15   max cycles in WAIT before abort (4-bit counter; must be >= 3)
//
// PORTS
// clk        in   1                clock, all state on rising edge
// reset      in   1                asynchronous, active-high
// req        in   N_PORTS          per-port request; held high until ack
// req_we     in   N_PORTS          per-port 1=write, 0=read; valid while req
// req_addr   in   N_PORTS*ADDR_W   per-port address, port i at [i*ADDR_W +: ADDR_W]
// req_wdata  in   N_PORTS*DATA_W   per-port write data, same packing
// ack        out  N_PORTS          one-cycle completion pulse to the granted port
// err        out  1                high with ack when the transaction timed out
// rdata      out  DATA_W           read data; valid in the ack cycle, held until the next read completes
// grant      out  N_PORTS          one-hot owner, high from ISSUE through DONE
// busy       out  1                state != ARB
// mem_addr   out  ADDR_W           to controller data_addr
// mem_wdata  out  DATA_W           to controller data_in
// mem_write  out  1                to controller write_data
// mem_read   out  1                to controller read_data
// mem_rdata  in   DATA_W           from controller data_out
// mem_ready  in   1                from controller, pulses on the last access cycle
// mem_idle   in   1                from controller, high when no access is in flight
//
// BEHAVIOUR
// - Reset: all outputs 0; state=ARB; last_grant=N_PORTS-1, so port 0 has top priority after reset.
// - FSM: ARB -> ISSUE -> WAIT -> DONE -> ARB.
// - ARB: if (|req) && mem_idle:
//   - pick the first set req scanning from last_grant+1 upward, modulo N_PORTS;
//   - register grant, we, addr and wdata from the winner; go to ISSUE.
//   - Otherwise stay in ARB. No grant is made while mem_idle=0.
// - ISSUE (exactly 1 cycle):
//   - mem_write = we or mem_read = !we, never both;
//   - mem_addr and mem_wdata come from the latched copy and stay stable through WAIT;
//   - go to WAIT.
// - WAIT: strobes low; cnt increments each cycle.
//   - On mem_ready: capture rdata <= mem_rdata for reads only; go to DONE.
//   - If cnt reaches TIMEOUT first: err_r <= 1; go to DONE.
// - DONE (1 cycle):
//   - ack[owner]=1, err=err_r;
//   - last_grant <= owner, cnt <= 0, err_r <= 0; go to ARB.
// - Latency on an idle system: req seen in cycle 0 -> ISSUE in cycle 1 -> controller
//   accesses in cycles 2-3 -> mem_ready in cycle 3 -> ack in cycle 4.
// - Request rules:
//   - A requester deasserts req in the cycle after ack; req still high in ARB counts as a new request.
//   - Dropping req mid-transaction does not cancel it; the access completes and ack still pulses.
//   - Changes to req_* inputs after grant are ignored (latched copy is used).
// - Fairness: a port re-requesting immediately loses to any other pending port; a sole requester wins back-to-back.
// - mem_ready seen outside WAIT is ignored.
// - Reset mid-transaction returns to ARB at once with no ack; the controller shares the same reset.
//
// TESTING
// - Single read, port 0, addr=0x00010, memory holds 0xBEEF -> ack[0] exactly 4 cycles after req, rdata=0xBEEF, err=0.
// - Write 0x1234 @0x00100 via port 2, then read it via port 1 -> mem_write pulse 1 cycle, read rdata=0x1234.
// - All 4 ports request together after reset -> grant order 0,1,2,3; port 0 re-requesting -> next after 3.
// - mem_idle held 0 while req[1]=1 -> no grant and no strobe until mem_idle=1.
// - mem_ready forced 0 -> ack with err=1 after TIMEOUT=15 WAIT cycles; next request is served normally.
// - Reset asserted in WAIT -> all outputs 0 next edge, no ack; port 0 has priority afterwards.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that shares the single 16-bit SRAM
// controller between N_PORTS requesters. One winner at a time gets a single
// read or write strobe; the arbiter then waits for the controller's ready
// pulse (or a watchdog timeout) and returns a one-cycle ack with read data.
// Every output is driven straight from a register.
module sram_arbiter #(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          req_we,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
    output logic [N_PORTS-1:0]          ack,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic [N_PORTS-1:0]          grant,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_write,
    output logic                        mem_read,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ready,
    input  logic                        mem_idle
);

    localparam int IDX_W = $clog2(N_PORTS);
    // WAIT gives up once this many cycles have gone by without mem_ready.
    localparam logic [3:0]         CNT_LAST  = 4'(TIMEOUT - 1);
    localparam logic [N_PORTS-1:0] ONE_HOT_0 = {{(N_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic [IDX_W-1:0]    last_grant_r, last_grant_s;
    logic [IDX_W-1:0]    owner_r, owner_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic [N_PORTS-1:0]  grant_r, grant_s;
    logic [N_PORTS-1:0]  ack_r, ack_s;
    logic                err_r, err_s;
    logic                busy_r, busy_s;
    logic                mem_write_r, mem_write_s;
    logic                mem_read_r, mem_read_s;

    logic [IDX_W-1:0]    cand_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                win_found_s;

    // Round-robin search: first requesting port after last_grant_r, wrapping.
    always_comb begin
        cand_s      = {IDX_W{1'b0}};
        win_idx_s   = {IDX_W{1'b0}};
        win_found_s = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand_s      = IDX_W'((int'(last_grant_r) + i) % N_PORTS);
            win_idx_s   = (!win_found_s && req[cand_s]) ? cand_s : win_idx_s;
            win_found_s = win_found_s | req[cand_s];
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that they appear registered in the state they belong to.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_grant_s = last_grant_r;
        owner_s      = owner_r;
        we_s         = we_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        rdata_s      = rdata_r;
        grant_s      = grant_r;
        ack_s        = {N_PORTS{1'b0}};
        err_s        = 1'b0;
        mem_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        case (state_r)
            ST_ARB: begin
                // A grant is only made while the controller is quiet.
                if (win_found_s && mem_idle) begin
                    state_s     = ST_ISSUE;
                    owner_s     = win_idx_s;
                    grant_s     = ONE_HOT_0 << win_idx_s;
                    we_s        = req_we[win_idx_s];
                    addr_s      = req_addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
                    wdata_s     = req_wdata[int'(win_idx_s) * DATA_W +: DATA_W];
                    mem_write_s = req_we[win_idx_s];
                    mem_read_s  = !req_we[win_idx_s];
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                cnt_s   = 4'd0;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_s = ST_DONE;
                    ack_s   = grant_r;
                    rdata_s = we_r ? rdata_r : mem_rdata;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    ack_s   = grant_r;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s      = ST_ARB;
                last_grant_s = owner_r;
                cnt_s        = 4'd0;
                grant_s      = {N_PORTS{1'b0}};
            end
            default: begin
                state_s = ST_ARB;
                cnt_s   = 4'd0;
                grant_s = {N_PORTS{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_ARB);
    end

    // State and output registers; reset leaves port 0 with top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_ARB;
            cnt_r        <= 4'd0;
            last_grant_r <= IDX_W'(N_PORTS - 1);
            owner_r      <= {IDX_W{1'b0}};
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            grant_r      <= {N_PORTS{1'b0}};
            ack_r        <= {N_PORTS{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_grant_r <= last_grant_s;
            owner_r      <= owner_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            rdata_r      <= rdata_s;
            grant_r      <= grant_s;
            ack_r        <= ack_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
            mem_write_r  <= mem_write_s;
            mem_read_r   <= mem_read_s;
        end
    end

    assign ack       = ack_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_write = mem_write_r;
    assign mem_read  = mem_read_r;

endmodule
